// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared constants, ratio type and helpers for the programmable
//            clock divider.
// Revision : 1.0
// ============================================================================
package clk_div_pkg;

    localparam int RATIO_W = 8;
    localparam int DIV_MIN = 2;

    typedef logic [RATIO_W-1:0] ratio_t;

    function automatic logic [31:0] half_floor(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_phase.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_phase
// Purpose  : Phase generation for the divider: posedge phase, negedge copy and
//            odd/even output mux giving a 50 % duty cycle for any ratio.
// Revision : 1.0
// ============================================================================
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int CNT_W = RATIO_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] n_act,
    output logic             clk_out
);

    logic             r_p_q;
    logic             r_n_q;
    logic             r_odd_q;
    logic [CNT_W-1:0] w_half;

    assign w_half = CNT_W'(half_floor(32'(n_act)));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_p_q   <= 1'b0;
            r_odd_q <= 1'b0;
        end else begin
            r_p_q   <= en && (cnt < w_half);
            r_odd_q <= n_act[0];
        end
    end

    // Half-cycle delayed copy stretches the high phase by 0.5 cycle for odd N.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            r_n_q <= 1'b0;
        end else begin
            r_n_q <= r_p_q;
        end
    end

    assign clk_out = r_odd_q ? (r_p_q | r_n_q) : r_p_q;

endmodule : clk_div_phase
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Purpose  : Runtime-programmable 50 % duty integer clock divider with
//            glitch-free ratio changes at period boundaries.
// Revision : 1.0
// ============================================================================
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = RATIO_W,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic             load_err
);

    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_div_min = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] c_div_def = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_n_act;
    logic [CNT_W-1:0] r_pend_val;
    logic             r_pend_vld;
    logic             r_tick;
    logic             r_load_ack;
    logic             r_load_err;

    logic             w_wrap;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_bypass;
    logic             w_apply;

    assign w_wrap     = en && (r_cnt == (r_n_act - c_one));
    assign w_load_ok  = div_load && (div_val >= c_div_min);
    assign w_load_bad = div_load && (div_val <  c_div_min);
    // A load landing exactly on the wrap edge takes effect at that same wrap.
    assign w_bypass   = w_load_ok && w_wrap;
    assign w_apply    = r_pend_vld && (w_wrap || !en);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_n_act    <= c_div_def;
            r_pend_val <= '0;
            r_pend_vld <= 1'b0;
            r_tick     <= 1'b0;
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tick     <= en && (r_cnt == '0);
            r_load_ack <= w_bypass || w_apply;
            r_load_err <= w_load_bad;

            if (w_bypass) begin
                r_n_act <= div_val;
            end else if (w_apply) begin
                r_n_act <= r_pend_val;
            end

            if (w_load_ok && !w_bypass) begin
                r_pend_val <= div_val;
                r_pend_vld <= 1'b1;
            end else if (w_bypass || w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    clk_div_phase #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .cnt     (r_cnt),
        .n_act   (r_n_act),
        .clk_out (clk_out)
    );

    assign tick     = r_tick;
    assign load_ack = r_load_ack;
    assign load_err = r_load_err;

endmodule : clk_div_prog
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_prog
// Purpose  : Self-checking bench for clk_div_prog against a half-cycle model.
// Revision : 1.0
// ============================================================================
module tb_clk_div_prog;
    import clk_div_pkg::*;

    localparam int CW  = 8;
    localparam int DEF = 5;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b1;
    logic          en       = 1'b0;
    logic [CW-1:0] div_val  = '0;
    logic          div_load = 1'b0;
    logic          clk_out;
    logic          tick;
    logic          load_ack;
    logic          load_err;

    clk_div_prog #(
        .CNT_W       (CW),
        .DIV_DEFAULT (DEF)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .load_ack (load_ack),
        .load_err (load_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: active ratio, pending load, period position, expectations.
    int m_n, m_cnt, m_pend_val;
    bit m_pend_vld, m_live;
    bit e_pos, e_neg, e_tick, e_ack, e_err;

    // Measurements derived from observed outputs.
    int cyc = 0, last_tick = 0, tick_gap = 0, hi_run = 0, hi_last = 0;
    int n_ticks = 0, n_acks = 0, n_errs = 0;

    task automatic model_step();
        int  n_cur;
        bit  wrap, ok, pos_hi, neg_hi;
        if (rst) begin
            m_live = 1; m_n = DEF; m_cnt = 0; m_pend_vld = 0; m_pend_val = 0;
            e_pos = 0; e_neg = 0; e_tick = 0; e_ack = 0; e_err = 0;
        end else if (m_live) begin
            n_cur = m_n;
            wrap  = en && (m_cnt == m_n - 1);
            ok    = div_load && (int'(div_val) >= DIV_MIN);
            e_err = div_load && (int'(div_val) < DIV_MIN);
            e_ack = 0;
            if (en) begin
                // Each period is high for exactly N half-cycles from its start.
                pos_hi = (2 * m_cnt) < n_cur;
                neg_hi = (2 * m_cnt + 1) < n_cur;
                e_tick = (m_cnt == 0);
                m_cnt  = wrap ? 0 : m_cnt + 1;
            end else begin
                pos_hi = ((n_cur % 2) == 1) && e_neg;
                neg_hi = 0;
                e_tick = 0;
                m_cnt  = 0;
            end
            if (ok && wrap) begin
                m_n = int'(div_val); m_pend_vld = 0; e_ack = 1;
            end else begin
                if (m_pend_vld && (wrap || !en)) begin
                    m_n = m_pend_val; m_pend_vld = 0; e_ack = 1;
                end
                if (ok) begin
                    m_pend_val = int'(div_val); m_pend_vld = 1;
                end
            end
            e_pos = pos_hi;
            e_neg = neg_hi;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            model_step();
            cyc++;
            #1;
            if (m_live) begin
                chk("clk_out_pos", {31'd0, clk_out}, {31'd0, e_pos});
                chk("tick", {31'd0, tick}, {31'd0, e_tick});
                chk("load_ack", {31'd0, load_ack}, {31'd0, e_ack});
                chk("load_err", {31'd0, load_err}, {31'd0, e_err});
                if (tick === 1'b1) begin
                    n_ticks++;
                    tick_gap  = cyc - last_tick;
                    last_tick = cyc;
                    hi_last   = hi_run;
                    hi_run    = 0;
                end
                if (load_ack === 1'b1) n_acks++;
                if (load_err === 1'b1) n_errs++;
                if (clk_out === 1'b1) hi_run++;
            end
            @(negedge clk_in);
            #1;
            if (m_live) begin
                chk("clk_out_neg", {31'd0, clk_out}, {31'd0, e_neg});
                if (clk_out === 1'b1) hi_run++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse_load(input int v);
        div_val  = CW'(v);
        div_load = 1'b1;
        @(negedge clk_in);
        div_load = 1'b0;
    endtask

    task automatic wait_tick();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            if (tick === 1'b1) seen = 1;
        end
        if (!seen) chk("wait_tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_period(input string tag, input int n);
        chk({tag, "_gap"}, tick_gap, n);
        chk({tag, "_high_halves"}, hi_last, n);
    endtask

    initial begin
        int t0, e0;
        cycles(3);
        chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_ack", {31'd0, load_ack}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        cycles(1);
        chk("startup_rise", {31'd0, clk_out}, 32'd1);
        chk("startup_tick", {31'd0, tick}, 32'd1);
        cycles(12);
        chk_period("n5", 5);

        wait_tick();
        e0 = n_errs;
        pulse_load(1);
        cycles(2);
        chk("err_div1", n_errs, e0 + 1);
        pulse_load(0);
        cycles(2);
        chk("err_div0", n_errs, e0 + 2);
        cycles(12);
        chk_period("n5_after_err", 5);
        chk("acks_after_err", n_acks, 0);

        wait_tick();
        cycles(1);
        pulse_load(4);
        cycles(14);
        chk("acks_n4", n_acks, 1);
        chk_period("n4", 4);

        wait_tick();
        pulse_load(7);
        pulse_load(3);
        cycles(12);
        chk("acks_last_wins", n_acks, 2);
        chk_period("n3", 3);

        pulse_load(6);
        cycles(16);
        chk("acks_n6", n_acks, 3);
        chk_period("n6", 6);

        wait_tick();
        cycles(1);
        en = 1'b0;
        t0 = n_ticks;
        cycles(2);
        chk("en_off_low", {31'd0, clk_out}, 32'd0);
        cycles(6);
        chk("en_off_no_tick", n_ticks, t0);
        en = 1'b1;
        cycles(1);
        chk("en_on_rise", {31'd0, clk_out}, 32'd1);
        chk("en_on_tick", {31'd0, tick}, 32'd1);
        cycles(14);
        chk_period("n6_restart", 6);

        pulse_load(9);
        cycles(25);
        chk("acks_n9", n_acks, 4);
        chk_period("n9", 9);

        wait_tick();
        pulse_load(4);
        rst = 1'b1;
        cycles(1);
        chk("midrst_clk_out", {31'd0, clk_out}, 32'd0);
        chk("midrst_tick", {31'd0, tick}, 32'd0);
        chk("midrst_ack", {31'd0, load_ack}, 32'd0);
        cycles(1);
        rst = 1'b0;
        cycles(16);
        chk("acks_pending_discarded", n_acks, 4);
        chk_period("n5_after_rst", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_prog
`default_nettype wire
